// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a stream of 32-bit big-endian message words into
// 512-bit SHA-224/256 blocks, applies FIPS 180-4 padding and drives the
// compression core's init/next strobes, reporting when the final digest is valid.
module sha256_msg_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic         core_digest_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    COLLECT,
    PAD,
    ISSUE,
    WAIT,
    DIGEST
  } state_t;

  state_t       state, state_nxt;
  logic [511:0] block_q, block_nxt;
  logic [3:0]   idx_q, idx_nxt;
  logic [60:0]  count_q, count_nxt;
  logic [6:0]   tail_q, tail_nxt;      // byte position just after the final data byte, 0..64
  logic         first_q, first_nxt;    // next strobe is core_init rather than core_next
  logic         final_q, final_nxt;    // block being issued is the last of the message
  logic         extra_q, extra_nxt;    // a length-only block still has to follow
  logic         marker_q, marker_nxt;  // that extra block also carries the 0x80 marker
  logic         settle_q, settle_nxt;  // first WAIT cycle, core_ready not yet meaningful
  logic         mode_q, mode_nxt;
  logic         busy_q, busy_nxt;

  logic [2:0]   eff_nbytes;
  logic [31:0]  byte_mask;
  logic [63:0]  bit_len;

  assign bit_len    = {count_q, 3'b000};
  assign core_block = block_q;
  assign core_mode  = mode_q;
  assign busy       = busy_q;

  // Bytes actually carried by the incoming word and the mask that zeroes the rest
  always_comb begin
    eff_nbytes = 3'd4;
    if (in_last && (in_nbytes < 3'd4)) eff_nbytes = in_nbytes;
    case (eff_nbytes)
      3'd0:    byte_mask = 32'h0000_0000;
      3'd1:    byte_mask = 32'hFF00_0000;
      3'd2:    byte_mask = 32'hFFFF_0000;
      3'd3:    byte_mask = 32'hFFFF_FF00;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
  end

  // State register and datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      block_q  <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      tail_q   <= '0;
      first_q  <= 1'b1;
      final_q  <= 1'b0;
      extra_q  <= 1'b0;
      marker_q <= 1'b0;
      settle_q <= 1'b0;
      mode_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      block_q  <= block_nxt;
      idx_q    <= idx_nxt;
      count_q  <= count_nxt;
      tail_q   <= tail_nxt;
      first_q  <= first_nxt;
      final_q  <= final_nxt;
      extra_q  <= extra_nxt;
      marker_q <= marker_nxt;
      settle_q <= settle_nxt;
      mode_q   <= mode_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // Next-state, block assembly, padding and core strobe generation
  always_comb begin
    state_nxt  = state;
    block_nxt  = block_q;
    idx_nxt    = idx_q;
    count_nxt  = count_q;
    tail_nxt   = tail_q;
    first_nxt  = first_q;
    final_nxt  = final_q;
    extra_nxt  = extra_q;
    marker_nxt = marker_q;
    settle_nxt = settle_q;
    mode_nxt   = mode_q;
    busy_nxt   = busy_q;
    in_ready   = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    done       = 1'b0;

    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int w = 0; w < 16; w++) begin
            if (4'(w) == idx_q) block_nxt[511 - 32*w -: 32] = in_data & byte_mask;
          end
          count_nxt = count_q + 61'(eff_nbytes);
          idx_nxt   = idx_q + 4'd1;
          if (!busy_q) begin
            mode_nxt = cfg_mode;
            busy_nxt = 1'b1;
          end
          if (in_last) begin
            tail_nxt  = {1'b0, idx_q, 2'b00} + {4'b0000, eff_nbytes};
            state_nxt = PAD;
          end else if (idx_q == 4'd15) begin
            final_nxt = 1'b0;
            extra_nxt = 1'b0;
            state_nxt = ISSUE;
          end
        end
      end

      PAD: begin
        state_nxt = ISSUE;
        if (tail_q == 7'd64) begin
          // data exactly fills the block: marker and length go into a fresh one
          final_nxt  = 1'b0;
          extra_nxt  = 1'b1;
          marker_nxt = 1'b1;
        end else begin
          for (int b = 0; b < 64; b++) begin
            if (7'(b) == tail_q)     block_nxt[511 - 8*b -: 8] = 8'h80;
            else if (7'(b) > tail_q) block_nxt[511 - 8*b -: 8] = 8'h00;
          end
          if (tail_q <= 7'd55) begin
            block_nxt[63:0] = bit_len;
            final_nxt       = 1'b1;
            extra_nxt       = 1'b0;
          end else begin
            final_nxt  = 1'b0;
            extra_nxt  = 1'b1;
            marker_nxt = 1'b0;
          end
        end
      end

      ISSUE: begin
        if (core_ready) begin
          core_init  = first_q;
          core_next  = !first_q;
          first_nxt  = 1'b0;
          settle_nxt = 1'b1;
          state_nxt  = WAIT;
        end
      end

      WAIT: begin
        if (settle_q) begin
          settle_nxt = 1'b0;
        end else if (core_ready) begin
          if (final_q) begin
            state_nxt = DIGEST;
          end else if (extra_q) begin
            block_nxt = '0;
            if (marker_q) block_nxt[511:504] = 8'h80;
            block_nxt[63:0] = bit_len;
            final_nxt  = 1'b1;
            extra_nxt  = 1'b0;
            marker_nxt = 1'b0;
            state_nxt  = ISSUE;
          end else begin
            idx_nxt   = '0;
            block_nxt = '0;
            state_nxt = COLLECT;
          end
        end
      end

      DIGEST: begin
        if (core_digest_valid) begin
          done      = 1'b1;
          busy_nxt  = 1'b0;
          count_nxt = '0;
          first_nxt = 1'b1;
          final_nxt = 1'b0;
          idx_nxt   = '0;
          block_nxt = '0;
          state_nxt = COLLECT;
        end
      end

      default: state_nxt = COLLECT;
    endcase
  end

endmodule
